// File: rtl/branch_pred_unit_pkg.sv
// Shared definitions for the branch unit: branch-type encodings, default
// parameter values and the branch-type qualifier.
package branch_pred_unit_pkg;

    localparam int DEF_DATA_W    = 32;
    localparam int DEF_PC_W      = 32;
    localparam int DEF_BHT_DEPTH = 64;
    localparam int DEF_CNT_W     = 2;
    localparam int DEF_INIT_CNT  = 1;
    localparam int DEF_STAT_W    = 32;

    typedef enum logic [2:0] {
        BR_BEQ  = 3'b000,
        BR_BNE  = 3'b001,
        BR_BGTZ = 3'b010,
        BR_BLTZ = 3'b011,
        BR_BLEZ = 3'b100,
        BR_BGEZ = 3'b101
    } br_type_e;

    // Encodings 110/111 are not branches and must never touch state.
    function automatic logic is_branch(input logic [2:0] br_type);
        return (br_type <= 3'b101);
    endfunction

endpackage

// File: rtl/branch_pred_unit_br_cond_eval.sv
// Combinational outcome of a conditional branch from its type and operands.
module br_cond_eval
    import branch_pred_unit_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic [2:0]        br_type,
    input  logic [DATA_W-1:0] rd1,
    input  logic [DATA_W-1:0] rd2,
    output logic              taken
);

    logic equal_s;
    logic rd1_zero_s;
    logic rd1_neg_s;

    assign equal_s    = (rd1 == rd2);
    assign rd1_zero_s = (rd1 == {DATA_W{1'b0}});
    assign rd1_neg_s  = rd1[DATA_W-1];

    // Signed compares against zero reduce to sign bit and zero detect.
    always_comb begin
        taken = 1'b0;
        case (br_type)
            BR_BEQ:  taken = equal_s;
            BR_BNE:  taken = !equal_s;
            BR_BGTZ: taken = !rd1_neg_s && !rd1_zero_s;
            BR_BLTZ: taken = rd1_neg_s;
            BR_BLEZ: taken = rd1_neg_s || rd1_zero_s;
            BR_BGEZ: taken = !rd1_neg_s;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_pred_unit.sv
// Branch resolution with a direct-mapped BHT of saturating counters,
// registered misprediction redirect and saturating statistics.
module branch_pred_unit
    import branch_pred_unit_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int PC_W      = DEF_PC_W,
    parameter int BHT_DEPTH = DEF_BHT_DEPTH,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int INIT_CNT  = DEF_INIT_CNT,
    parameter int STAT_W    = DEF_STAT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [PC_W-1:0]   if_pc_i,
    output logic              pred_taken_o,
    input  logic              res_valid_i,
    input  logic [PC_W-1:0]   res_pc_i,
    input  logic [2:0]        res_type_i,
    input  logic              res_pred_i,
    input  logic [DATA_W-1:0] rd1_i,
    input  logic [DATA_W-1:0] rd2_i,
    input  logic [PC_W-1:0]   res_target_i,
    input  logic [PC_W-1:0]   res_fallthru_i,
    input  logic              clr_stats_i,
    output logic              taken_o,
    output logic              redirect_o,
    output logic [PC_W-1:0]   redirect_pc_o,
    output logic [STAT_W-1:0] branch_cnt_o,
    output logic [STAT_W-1:0] mispred_cnt_o
);

    localparam int               IDX_W    = $clog2(BHT_DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_RST  = CNT_W'(INIT_CNT);
    localparam logic [STAT_W-1:0] STAT_MAX  = {STAT_W{1'b1}};
    localparam logic [STAT_W-1:0] STAT_ZERO = {STAT_W{1'b0}};
    localparam logic [STAT_W-1:0] STAT_ONE  = STAT_W'(1);

    logic [CNT_W-1:0]  bht_r [BHT_DEPTH];
    logic [IDX_W-1:0]  if_idx_s;
    logic [IDX_W-1:0]  res_idx_s;
    logic [CNT_W-1:0]  bht_cur_s;
    logic [CNT_W-1:0]  bht_nxt_s;
    logic              cond_taken_s;
    logic              valid_s;
    logic              mispred_s;
    logic              redirect_r;
    logic [PC_W-1:0]   redirect_pc_r;
    logic [STAT_W-1:0] branch_cnt_r;
    logic [STAT_W-1:0] mispred_cnt_r;
    logic              unused_pc_bits_s;

    assign if_idx_s  = if_pc_i[IDX_W+1:2];
    assign res_idx_s = res_pc_i[IDX_W+1:2];
    assign unused_pc_bits_s = ^{if_pc_i[PC_W-1:IDX_W+2], if_pc_i[1:0],
                                res_pc_i[PC_W-1:IDX_W+2], res_pc_i[1:0]};

    br_cond_eval #(
        .DATA_W (DATA_W)
    ) u_cond (
        .br_type (res_type_i),
        .rd1     (rd1_i),
        .rd2     (rd2_i),
        .taken   (cond_taken_s)
    );

    assign valid_s      = res_valid_i && is_branch(res_type_i);
    assign taken_o      = valid_s && cond_taken_s;
    assign mispred_s    = valid_s && (taken_o != res_pred_i);
    // Read port sees the stored value only; a same-cycle update is not bypassed.
    assign pred_taken_o = bht_r[if_idx_s][CNT_W-1];
    assign bht_cur_s    = bht_r[res_idx_s];

    // Saturating next value for the counter of the resolving branch.
    always_comb begin
        bht_nxt_s = bht_cur_s;
        if (taken_o) begin
            if (bht_cur_s != CNT_MAX) begin
                bht_nxt_s = bht_cur_s + CNT_ONE;
            end else begin
                bht_nxt_s = bht_cur_s;
            end
        end else begin
            if (bht_cur_s != CNT_ZERO) begin
                bht_nxt_s = bht_cur_s - CNT_ONE;
            end else begin
                bht_nxt_s = bht_cur_s;
            end
        end
    end

    // BHT storage, trained only by valid branches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                bht_r[i] <= CNT_RST;
            end
        end else if (valid_s) begin
            bht_r[res_idx_s] <= bht_nxt_s;
        end
    end

    // Redirect pulse and corrected PC; the PC holds between mispredictions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_r    <= 1'b0;
            redirect_pc_r <= {PC_W{1'b0}};
        end else begin
            redirect_r <= mispred_s;
            if (mispred_s) begin
                redirect_pc_r <= taken_o ? res_target_i : res_fallthru_i;
            end
        end
    end

    // Statistics; clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_cnt_r  <= STAT_ZERO;
            mispred_cnt_r <= STAT_ZERO;
        end else if (clr_stats_i) begin
            branch_cnt_r  <= STAT_ZERO;
            mispred_cnt_r <= STAT_ZERO;
        end else begin
            if (valid_s && (branch_cnt_r != STAT_MAX)) begin
                branch_cnt_r <= branch_cnt_r + STAT_ONE;
            end
            if (mispred_s && (mispred_cnt_r != STAT_MAX)) begin
                mispred_cnt_r <= mispred_cnt_r + STAT_ONE;
            end
        end
    end

    assign redirect_o    = redirect_r;
    assign redirect_pc_o = redirect_pc_r;
    assign branch_cnt_o  = branch_cnt_r;
    assign mispred_cnt_o = mispred_cnt_r;

endmodule

// File: tb/tb_branch_pred_unit.sv
// Self-checking bench: directed scenarios with literal expectations plus
// random resolves compared every cycle against a behavioural model.
module tb_branch_pred_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] if_pc_i = 32'h0;
    logic        pred_taken_o;
    logic        res_valid_i = 1'b0;
    logic [31:0] res_pc_i = 32'h0;
    logic [2:0]  res_type_i = 3'b000;
    logic        res_pred_i = 1'b0;
    logic [31:0] rd1_i = 32'h0;
    logic [31:0] rd2_i = 32'h0;
    logic [31:0] res_target_i = 32'h0;
    logic [31:0] res_fallthru_i = 32'h0;
    logic        clr_stats_i = 1'b0;
    logic        taken_o;
    logic        redirect_o;
    logic [31:0] redirect_pc_o;
    logic [31:0] branch_cnt_o;
    logic [31:0] mispred_cnt_o;

    int n_total = 0;
    int n_pass  = 0;

    branch_pred_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .if_pc_i        (if_pc_i),
        .pred_taken_o   (pred_taken_o),
        .res_valid_i    (res_valid_i),
        .res_pc_i       (res_pc_i),
        .res_type_i     (res_type_i),
        .res_pred_i     (res_pred_i),
        .rd1_i          (rd1_i),
        .rd2_i          (rd2_i),
        .res_target_i   (res_target_i),
        .res_fallthru_i (res_fallthru_i),
        .clr_stats_i    (clr_stats_i),
        .taken_o        (taken_o),
        .redirect_o     (redirect_o),
        .redirect_pc_o  (redirect_pc_o),
        .branch_cnt_o   (branch_cnt_o),
        .mispred_cnt_o  (mispred_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Reference model: counters as plain integers 0..3, stats as longints.
    int      m_bht [64];
    bit      m_redir;
    longint  m_redir_pc;
    longint  m_bcnt;
    longint  m_mcnt;

    function automatic bit m_taken(bit v, logic [2:0] t, logic [31:0] a, logic [31:0] b);
        if (!v) return 1'b0;
        case (t)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd2: return $signed(a) > 0;
            3'd3: return $signed(a) < 0;
            3'd4: return $signed(a) <= 0;
            3'd5: return $signed(a) >= 0;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit m_valid(bit v, logic [2:0] t);
        return v && (t <= 3'd5);
    endfunction

    function automatic int m_next(int c, bit tk);
        if (tk) return (c < 3) ? c + 1 : 3;
        return (c > 0) ? c - 1 : 0;
    endfunction

    function automatic longint m_inc(longint c);
        return (c < 64'hFFFF_FFFF) ? c + 1 : c;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 64; i++) m_bht[i] <= 1;
            m_redir    <= 1'b0;
            m_redir_pc <= 0;
            m_bcnt     <= 0;
            m_mcnt     <= 0;
        end else begin
            if (m_valid(res_valid_i, res_type_i))
                m_bht[res_pc_i[7:2]] <= m_next(m_bht[res_pc_i[7:2]],
                    m_taken(res_valid_i, res_type_i, rd1_i, rd2_i));
            m_redir <= m_valid(res_valid_i, res_type_i) &&
                       (m_taken(res_valid_i, res_type_i, rd1_i, rd2_i) != res_pred_i);
            if (m_valid(res_valid_i, res_type_i) &&
                (m_taken(res_valid_i, res_type_i, rd1_i, rd2_i) != res_pred_i))
                m_redir_pc <= m_taken(res_valid_i, res_type_i, rd1_i, rd2_i) ?
                              res_target_i : res_fallthru_i;
            if (clr_stats_i) begin
                m_bcnt <= 0;
                m_mcnt <= 0;
            end else begin
                if (m_valid(res_valid_i, res_type_i)) m_bcnt <= m_inc(m_bcnt);
                if (m_valid(res_valid_i, res_type_i) &&
                    (m_taken(res_valid_i, res_type_i, rd1_i, rd2_i) != res_pred_i))
                    m_mcnt <= m_inc(m_mcnt);
            end
        end
    end

    // Compare every falling edge, away from the active edge.
    always @(negedge clk) begin
        chk("pred_taken", {63'd0, pred_taken_o}, {63'd0, m_bht[if_pc_i[7:2]] >= 2});
        chk("taken", {63'd0, taken_o},
            {63'd0, m_taken(res_valid_i, res_type_i, rd1_i, rd2_i)});
        chk("redirect", {63'd0, redirect_o}, {63'd0, m_redir});
        chk("redirect_pc", {32'd0, redirect_pc_o}, m_redir_pc);
        chk("branch_cnt", {32'd0, branch_cnt_o}, m_bcnt);
        chk("mispred_cnt", {32'd0, mispred_cnt_o}, m_mcnt);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic res(input logic [31:0] pc, input logic [2:0] t, input logic pred,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] tgt, input logic [31:0] ft);
        res_valid_i = 1'b1; res_pc_i = pc; res_type_i = t; res_pred_i = pred;
        rd1_i = a; rd2_i = b; res_target_i = tgt; res_fallthru_i = ft;
        #1;
    endtask

    task automatic idle();
        res_valid_i = 1'b0; clr_stats_i = 1'b0;
        #1;
    endtask

    initial begin
        logic [31:0] neg;
        #2 rst_n = 1'b0;
        if_pc_i = 32'h40;
        step(); step();
        rst_n = 1'b1;
        #1;
        chk("rst_pred", {63'd0, pred_taken_o}, 64'd0);
        chk("rst_redirect", {63'd0, redirect_o}, 64'd0);
        chk("rst_bcnt", {32'd0, branch_cnt_o}, 64'd0);
        chk("rst_mcnt", {32'd0, mispred_cnt_o}, 64'd0);
        step();

        // bne mispredicted as not taken
        res(32'h40, 3'b001, 1'b0, 32'd5, 32'd7, 32'h80, 32'h44);
        chk("bne_taken", {63'd0, taken_o}, 64'd1);
        step(); idle();
        chk("bne_redirect", {63'd0, redirect_o}, 64'd1);
        chk("bne_redirect_pc", {32'd0, redirect_pc_o}, 64'h80);
        chk("bne_mcnt", {32'd0, mispred_cnt_o}, 64'd1);
        chk("bne_bcnt", {32'd0, branch_cnt_o}, 64'd1);
        chk("bne_pred", {63'd0, pred_taken_o}, 64'd1);
        step();
        chk("bne_redirect_drop", {63'd0, redirect_o}, 64'd0);

        // signed compares
        neg = 32'h8000_0000;
        res(32'h100, 3'b011, 1'b1, neg, 32'd0, 32'h0, 32'h104);
        chk("bltz_neg", {63'd0, taken_o}, 64'd1);
        res(32'h100, 3'b101, 1'b1, neg, 32'd0, 32'h0, 32'h104);
        chk("bgez_neg", {63'd0, taken_o}, 64'd0);
        res(32'h100, 3'b100, 1'b1, neg, 32'd0, 32'h0, 32'h104);
        chk("blez_neg", {63'd0, taken_o}, 64'd1);
        res(32'h100, 3'b010, 1'b1, neg, 32'd0, 32'h0, 32'h104);
        chk("bgtz_neg", {63'd0, taken_o}, 64'd0);
        res(32'h100, 3'b100, 1'b1, 32'd0, 32'd0, 32'h0, 32'h104);
        chk("blez_zero", {63'd0, taken_o}, 64'd1);
        res(32'h100, 3'b010, 1'b1, 32'd0, 32'd0, 32'h0, 32'h104);
        chk("bgtz_zero", {63'd0, taken_o}, 64'd0);
        step(); idle(); step();

        // saturation at index 0
        if_pc_i = 32'h200;
        for (int i = 0; i < 5; i++) begin
            res(32'h200, 3'b000, 1'b1, 32'd9, 32'd9, 32'h300, 32'h204);
            step();
        end
        res(32'h200, 3'b000, 1'b1, 32'd1, 32'd2, 32'h300, 32'h204);
        step(); idle();
        chk("sat_after_one_dec", {63'd0, pred_taken_o}, 64'd1);
        res(32'h200, 3'b000, 1'b1, 32'd1, 32'd2, 32'h300, 32'h204);
        step(); idle();
        chk("sat_after_two_dec", {63'd0, pred_taken_o}, 64'd0);
        step();

        // same-cycle read and write at index 3
        if_pc_i = 32'h0C;
        res(32'h0C, 3'b000, 1'b0, 32'd4, 32'd4, 32'h500, 32'h10);
        chk("rdw_old", {63'd0, pred_taken_o}, 64'd0);
        step(); idle();
        chk("rdw_new", {63'd0, pred_taken_o}, 64'd1);
        step();

        // back-to-back mispredictions
        res(32'h20, 3'b001, 1'b0, 32'd1, 32'd3, 32'h300, 32'h24);
        step();
        res(32'h400, 3'b000, 1'b1, 32'd1, 32'd2, 32'h600, 32'h404);
        chk("b2b_first_redirect", {63'd0, redirect_o}, 64'd1);
        chk("b2b_first_pc", {32'd0, redirect_pc_o}, 64'h300);
        step(); idle();
        chk("b2b_second_redirect", {63'd0, redirect_o}, 64'd1);
        chk("b2b_second_pc", {32'd0, redirect_pc_o}, 64'h404);
        step();
        chk("b2b_drop", {63'd0, redirect_o}, 64'd0);
        chk("b2b_pc_hold", {32'd0, redirect_pc_o}, 64'h404);

        // not-a-branch type: no state change
        begin
            logic [31:0] bc;
            bc = branch_cnt_o;
            res(32'h0C, 3'b110, 1'b0, 32'd4, 32'd4, 32'h700, 32'h10);
            chk("nb_taken", {63'd0, taken_o}, 64'd0);
            step(); idle();
            chk("nb_count", {32'd0, branch_cnt_o}, {32'd0, bc});
            chk("nb_redirect", {63'd0, redirect_o}, 64'd0);
        end
        step();

        // clear together with a mispredict
        res(32'h80, 3'b001, 1'b0, 32'd1, 32'd2, 32'h900, 32'h84);
        clr_stats_i = 1'b1;
        step(); idle();
        chk("clr_bcnt", {32'd0, branch_cnt_o}, 64'd0);
        chk("clr_mcnt", {32'd0, mispred_cnt_o}, 64'd0);
        chk("clr_redirect", {63'd0, redirect_o}, 64'd1);
        chk("clr_redirect_pc", {32'd0, redirect_pc_o}, 64'h900);

        // reset while redirect is high
        res(32'h80, 3'b001, 1'b0, 32'd1, 32'd2, 32'hA00, 32'h84);
        step(); idle();
        chk("pre_rst_redirect", {63'd0, redirect_o}, 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_redirect", {63'd0, redirect_o}, 64'd0);
        chk("mid_rst_pc", {32'd0, redirect_pc_o}, 64'd0);
        step();
        rst_n = 1'b1;
        step();

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] a;
            case ($urandom_range(0, 5))
                0: a = 32'd0;
                1: a = 32'h8000_0000;
                2: a = 32'hFFFF_FFFF;
                3: a = 32'd1;
                4: a = 32'h7FFF_FFFF;
                default: a = $urandom;
            endcase
            res_valid_i    = ($urandom_range(0, 3) != 0);
            res_pc_i       = {$urandom_range(0, 255), 2'b00} | ($urandom & 32'hFFFF_0000);
            res_type_i     = 3'($urandom_range(0, 7));
            res_pred_i     = 1'($urandom_range(0, 1));
            rd1_i          = a;
            rd2_i          = ($urandom_range(0, 1) != 0) ? a : $urandom;
            res_target_i   = $urandom;
            res_fallthru_i = res_pc_i + 32'd4;
            clr_stats_i    = ($urandom_range(0, 31) == 0);
            if_pc_i        = ($urandom_range(0, 1) != 0) ? res_pc_i : {$urandom_range(0, 255), 2'b00};
            step();
        end
        idle();
        step(); step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
